// File: rtl/alu_accum_seq.sv
// Small sequential ALU with an accumulator result register and an iterative shift-add multiplier.
// Single-cycle ops complete at the accept edge; MUL walks one multiplier bit per cycle.
module alu_accum_seq #(
  parameter int WIDTH      = 4,
  parameter bit B_FROM_REG = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  output logic               busy,
  output logic [2*WIDTH-1:0] R,
  output logic               carry
);

  localparam int RW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_ACC    = 3'b001;
  localparam logic [2:0] OP_LOGIC  = 3'b010;
  localparam logic [2:0] OP_ORRED  = 3'b011;
  localparam logic [2:0] OP_ANDRED = 3'b100;
  localparam logic [2:0] OP_CONCAT = 3'b101;
  localparam logic [2:0] OP_MUL    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      r_q, r_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [RW-1:0]      prod_q, prod_d;

  logic [WIDTH-1:0]   b_op;
  logic               accept;
  logic [WIDTH:0]     add_sum;
  logic [RW:0]        acc_sum;
  logic [RW-1:0]      mcand_shift;
  logic [RW-1:0]      pp_next;
  logic               last_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      r_q      <= '0;
      carry_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      carry_q  <= carry_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      prod_q   <= prod_d;
    end
  end

  // Datapath helpers shared by the single-cycle ops and the multiplier step.
  always_comb begin
    b_op        = B_FROM_REG ? r_q[WIDTH-1:0] : b;
    accept      = in_valid && (state_q == IDLE);
    add_sum     = {1'b0, a} + {1'b0, b_op};
    acc_sum     = {1'b0, r_q} + {{(RW + 1 - WIDTH){1'b0}}, a};
    mcand_shift = {{WIDTH{1'b0}}, mcand_q} << count_q;
    pp_next     = prod_q + (mplier_q[count_q] ? mcand_shift : '0);
    last_step   = (count_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    carry_d  = carry_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    prod_d   = prod_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DONE;
          case (op)
            OP_ADD: begin
              r_d     = {{(RW - WIDTH - 1){1'b0}}, add_sum};
              carry_d = add_sum[WIDTH];
            end
            OP_ACC: begin
              r_d     = acc_sum[RW-1:0];
              carry_d = acc_sum[RW];
            end
            OP_LOGIC:  r_d = {a ^ b_op, a | b_op};
            OP_ORRED:  r_d = ((|a) || (|b_op)) ? {1'b1, {(RW - 2){1'b0}}, 1'b1} : '0;
            OP_ANDRED: r_d = ((&a) && (&b_op)) ? {1'b0, {(RW - 2){1'b1}}, 1'b0} : '0;
            OP_CONCAT: r_d = {b_op, a};
            OP_MUL: begin
              // R keeps its old value until the product is complete.
              state_d  = MUL;
              mcand_d  = a;
              mplier_d = b_op;
              count_d  = '0;
              prod_d   = '0;
            end
            default: r_d = r_q;
          endcase
        end
      end
      MUL: begin
        prod_d  = pp_next;
        count_d = count_q + CNT_W'(1);
        if (last_step) begin
          r_d     = pp_next;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == MUL);
  assign R         = r_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_alu_accum_seq.sv
// Randomized and directed bench for alu_accum_seq, with one instance per B operand source.
// Expected results come from a plain-arithmetic model of each op.
module tb_alu_accum_seq;

  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         in_valid;
  logic         target;

  logic          in_valid0, in_valid1;
  logic          in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1, carry0, carry1;
  logic [RW-1:0] r0, r1;

  logic          obs_ready, obs_valid, obs_busy, obs_carry;
  logic [RW-1:0] obs_r;

  int total = 0;
  int bad   = 0;
  int m_r[2];
  int m_c[2];

  assign in_valid0 = in_valid && !target;
  assign in_valid1 = in_valid && target;
  assign obs_ready = target ? in_ready1  : in_ready0;
  assign obs_valid = target ? out_valid1 : out_valid0;
  assign obs_busy  = target ? busy1      : busy0;
  assign obs_carry = target ? carry1     : carry0;
  assign obs_r     = target ? r1         : r0;

  alu_accum_seq #(.WIDTH(W), .B_FROM_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_valid(out_valid0), .busy(busy0), .R(r0), .carry(carry0)
  );

  alu_accum_seq #(.WIDTH(W), .B_FROM_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_valid(out_valid1), .busy(busy1), .R(r1), .carry(carry1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of one accepted operation on instance t.
  task automatic modelOp(input int t, input int o, input int av, input int bv);
    int bop, s, full;
    full = 1 << RW;
    bop  = (t == 1) ? (m_r[t] % (1 << W)) : bv;
    case (o)
      0: begin s = av + bop;     m_r[t] = s;        m_c[t] = (s >= (1 << W)) ? 1 : 0; end
      1: begin s = m_r[t] + av;  m_r[t] = s % full; m_c[t] = (s >= full) ? 1 : 0; end
      2: m_r[t] = (av ^ bop) * (1 << W) + (av | bop);
      3: m_r[t] = (av != 0 || bop != 0) ? ((1 << (RW - 1)) + 1) : 0;
      4: m_r[t] = (av == (1 << W) - 1 && bop == (1 << W) - 1) ? ((1 << (RW - 1)) - 2) : 0;
      5: m_r[t] = bop * (1 << W) + av;
      6: m_r[t] = av * bop;
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input int t, input int o, input int av, input int bv, input bit hold_valid);
    int waits, idx, busy_n;
    @(negedge clk);
    target   = t[0];
    op       = o[2:0];
    a        = av[W-1:0];
    b        = bv[W-1:0];
    in_valid = 1'b1;
    waits    = 0;
    while (!obs_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("ready_before_accept", obs_ready, 1);
    modelOp(t, o, av, bv);
    @(posedge clk);
    #1;
    if (hold_valid) op = 3'b000;
    else in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    checkOutput("ready_after_accept", obs_ready, 0);
    idx    = 1;
    busy_n = 0;
    while (!obs_valid && idx < 20) begin
      if (obs_busy) busy_n++;
      @(posedge clk);
      #1;
      idx++;
    end
    checkOutput($sformatf("latency_op%0d", o), idx, (o == 6) ? W + 1 : 1);
    checkOutput($sformatf("busy_cycles_op%0d", o), busy_n, (o == 6) ? W : 0);
    checkOutput($sformatf("r_op%0d_t%0d", o, t), obs_r, m_r[t]);
    checkOutput($sformatf("carry_op%0d_t%0d", o, t), obs_carry, m_c[t]);
    checkOutput("ready_in_done", obs_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("valid_one_cycle", obs_valid, 0);
    checkOutput("ready_back_idle", obs_ready, 1);
    if (hold_valid) begin
      @(posedge clk);
      #1;
      checkOutput("no_queued_op_valid", obs_valid, 0);
      checkOutput("no_queued_op_r", obs_r, m_r[t]);
    end
  endtask

  initial begin
    bit seen;
    rst      = 1'b1;
    in_valid = 1'b0;
    target   = 1'b0;
    op       = 3'b000;
    a        = '0;
    b        = '0;
    m_r[0] = 0; m_r[1] = 0; m_c[0] = 0; m_c[1] = 0;
    #2;
    checkOutput("reset_r", r0, 0);
    checkOutput("reset_carry", carry0, 0);
    checkOutput("reset_ready", in_ready0, 1);
    checkOutput("reset_valid", out_valid0, 0);
    checkOutput("reset_busy", busy0, 0);
    checkOutput("reset_r_breg", r1, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 0, 9, 8, 0);
    checkOutput("vec_add_r", r0, 8'h11);
    checkOutput("vec_add_carry", carry0, 1);
    applyStimulus(0, 6, 15, 15, 1);
    checkOutput("vec_mul_ff", r0, 8'hE1);
    applyStimulus(0, 6, 0, 13, 0);
    checkOutput("vec_mul_zero", r0, 8'h00);
    applyStimulus(0, 5, 14, 15, 0);
    applyStimulus(0, 1, 3, 0, 0);
    checkOutput("vec_acc_r", r0, 8'h01);
    checkOutput("vec_acc_carry", carry0, 1);
    applyStimulus(0, 2, 10, 5, 0);
    checkOutput("vec_logic_r", r0, 8'hFF);
    checkOutput("vec_logic_carry", carry0, 1);
    applyStimulus(0, 3, 0, 0, 0);
    checkOutput("vec_orred_zero", r0, 8'h00);
    applyStimulus(0, 3, 0, 4, 0);
    checkOutput("vec_orred_one", r0, 8'h81);
    applyStimulus(0, 4, 15, 15, 0);
    checkOutput("vec_andred_all", r0, 8'h7E);
    applyStimulus(0, 4, 15, 14, 0);
    checkOutput("vec_andred_not", r0, 8'h00);
    applyStimulus(0, 7, 3, 3, 0);

    applyStimulus(1, 0, 3, 9, 0);
    checkOutput("vec_breg_init", r1, 8'h03);
    applyStimulus(1, 5, 6, 1, 0);
    checkOutput("vec_breg_concat", r1, 8'h36);
    applyStimulus(1, 6, 2, 9, 0);
    checkOutput("vec_breg_mul", r1, 8'h0C);

    // Abort a multiply in its second cycle with an asynchronous reset.
    @(negedge clk);
    target   = 1'b0;
    op       = 3'b110;
    a        = 4'd7;
    b        = 4'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_busy_before", busy0, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_r", r0, 0);
    checkOutput("abort_ready", in_ready0, 1);
    checkOutput("abort_busy", busy0, 0);
    checkOutput("abort_valid", out_valid0, 0);
    checkOutput("abort_carry", carry0, 0);
    m_r[0] = 0; m_r[1] = 0; m_c[0] = 0; m_c[1] = 0;
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid0) seen = 1'b1;
    end
    checkOutput("abort_no_valid", seen, 0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15),
                    $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
